// File: rtl/uart_cmd_decoder.sv
// Command decoder for a UART-fed acquisition controller.
// It takes an assembled 32-bit frame (opcode + 24-bit argument), updates the
// capture configuration and returns a byte-wise response to the transmitter.
module uart_cmd_decoder #(
    parameter logic [23:0] DIV_RESET = 24'd1000,
    parameter logic [7:0]  ACK_OK    = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] frame_data,
    input  logic        frame_done,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [23:0] sample_div,
    output logic [7:0]  trig_level,
    output logic [1:0]  trig_mode,
    output logic        trig_edge,
    output logic        run,
    output logic        cmd_err,
    output logic [7:0]  err_count
);

    localparam int unsigned OP_W  = 8;
    localparam int unsigned ARG_W = 24;
    localparam int unsigned CNT_W = 2;

    localparam logic [OP_W-1:0] OP_DIV   = 8'h01;
    localparam logic [OP_W-1:0] OP_LEVEL = 8'h02;
    localparam logic [OP_W-1:0] OP_TRIG  = 8'h03;
    localparam logic [OP_W-1:0] OP_RUN   = 8'h04;
    localparam logic [OP_W-1:0] OP_QUERY = 8'h05;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2,
        ACK  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic               done_prev;
    logic [OP_W-1:0]    op, op_nxt;
    logic [ARG_W-1:0]   arg, arg_nxt;
    logic [ARG_W-1:0]   resp_shift, resp_shift_nxt;
    logic [CNT_W-1:0]   bytes_left, bytes_left_nxt;
    logic [7:0]         tx_data_nxt;
    logic               tx_valid_nxt;
    logic [23:0]        sample_div_nxt;
    logic [7:0]         trig_level_nxt;
    logic [1:0]         trig_mode_nxt;
    logic               trig_edge_nxt;
    logic               run_nxt;
    logic               err_pulse;
    logic [7:0]         err_count_nxt;
    logic               illegal;
    logic               frame_start;
    logic               xfer;
    logic [ARG_W-1:0]   query_val;

    assign frame_start = frame_done & ~done_prev;
    assign xfer        = tx_valid & tx_ready;

    // Value selected by a query frame, taken from the current configuration
    always_comb begin
        case (arg[1:0])
            2'd0:    query_val = sample_div;
            2'd1:    query_val = {16'h0000, trig_level};
            2'd2:    query_val = {21'h000000, trig_edge, trig_mode};
            default: query_val = {23'h000000, run};
        endcase
    end

    // Next-state, configuration update and response sequencing
    always_comb begin
        state_nxt      = state;
        op_nxt         = op;
        arg_nxt        = arg;
        resp_shift_nxt = resp_shift;
        bytes_left_nxt = bytes_left;
        tx_data_nxt    = tx_data;
        tx_valid_nxt   = tx_valid;
        sample_div_nxt = sample_div;
        trig_level_nxt = trig_level;
        trig_mode_nxt  = trig_mode;
        trig_edge_nxt  = trig_edge;
        run_nxt        = run;
        err_pulse      = 1'b0;
        illegal        = 1'b0;

        case (state)
            IDLE: begin
                if (frame_start) begin
                    op_nxt    = frame_data[31:24];
                    arg_nxt   = frame_data[23:0];
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                tx_valid_nxt = 1'b1;
                tx_data_nxt  = ACK_OK;
                state_nxt    = ACK;
                case (op)
                    OP_DIV: begin
                        if (arg == '0) illegal = 1'b1;
                        else           sample_div_nxt = arg;
                    end
                    OP_LEVEL: trig_level_nxt = arg[7:0];
                    OP_TRIG: begin
                        if (arg[1:0] == 2'd3) begin
                            illegal = 1'b1;
                        end else begin
                            trig_mode_nxt = arg[1:0];
                            trig_edge_nxt = arg[8];
                        end
                    end
                    OP_RUN: run_nxt = arg[0];
                    OP_QUERY: begin
                        tx_data_nxt    = query_val[23:16];
                        resp_shift_nxt = {query_val[15:0], 8'h00};
                        bytes_left_nxt = CNT_W'(2);
                        state_nxt      = RESP;
                    end
                    default: illegal = 1'b1;
                endcase
                if (illegal) begin
                    tx_data_nxt = {4'hE, op[3:0]};
                    err_pulse   = 1'b1;
                end
            end
            RESP: begin
                if (xfer) begin
                    if (bytes_left != '0) begin
                        tx_data_nxt    = resp_shift[23:16];
                        resp_shift_nxt = {resp_shift[15:0], 8'h00};
                        bytes_left_nxt = bytes_left - CNT_W'(1);
                    end else begin
                        tx_data_nxt = ACK_OK;
                        state_nxt   = ACK;
                    end
                end
            end
            ACK: begin
                if (xfer) begin
                    tx_valid_nxt = 1'b0;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A frame arriving while busy is dropped; merges with a reject pulse
        if (frame_start && (state != IDLE)) err_pulse = 1'b1;

        err_count_nxt = (err_pulse && (err_count != 8'hFF)) ? err_count + 8'd1 : err_count;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            done_prev  <= 1'b0;
            op         <= '0;
            arg        <= '0;
            resp_shift <= '0;
            bytes_left <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            sample_div <= DIV_RESET;
            trig_level <= 8'h80;
            trig_mode  <= 2'd0;
            trig_edge  <= 1'b0;
            run        <= 1'b0;
            cmd_err    <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_nxt;
            done_prev  <= frame_done;
            op         <= op_nxt;
            arg        <= arg_nxt;
            resp_shift <= resp_shift_nxt;
            bytes_left <= bytes_left_nxt;
            tx_data    <= tx_data_nxt;
            tx_valid   <= tx_valid_nxt;
            sample_div <= sample_div_nxt;
            trig_level <= trig_level_nxt;
            trig_mode  <= trig_mode_nxt;
            trig_edge  <= trig_edge_nxt;
            run        <= run_nxt;
            cmd_err    <= err_pulse;
            err_count  <= err_count_nxt;
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: a frame/byte-queue reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_uart_cmd_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] frame_data;
    logic        frame_done;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [23:0] sample_div;
    logic [7:0]  trig_level;
    logic [1:0]  trig_mode;
    logic        trig_edge;
    logic        run;
    logic        cmd_err;
    logic [7:0]  err_count;

    uart_cmd_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .frame_data (frame_data),
        .frame_done (frame_done),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .sample_div (sample_div),
        .trig_level (trig_level),
        .trig_mode  (trig_mode),
        .trig_edge  (trig_edge),
        .run        (run),
        .cmd_err    (cmd_err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    bit toggle_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: configuration, error counter and a queue of pending response bytes
    logic [23:0] m_div;
    logic [7:0]  m_lvl;
    logic [1:0]  m_mode;
    logic        m_edge;
    logic        m_run;
    logic        m_err;
    logic [7:0]  m_cnt;
    logic [7:0]  q[$];
    bit          m_busy;
    bit          m_pend;
    bit          m_prev;
    logic [31:0] m_frame;

    always @(posedge clk) begin : model
        bit          xfer_m;
        bit          det;
        bit          busy0;
        bit          ok;
        logic [7:0]  op;
        logic [23:0] a;
        logic [23:0] qv;
        if (reset) begin
            m_div = 24'd1000; m_lvl = 8'h80; m_mode = 2'd0; m_edge = 1'b0; m_run = 1'b0;
            m_err = 1'b0; m_cnt = 8'd0; q.delete();
            m_busy = 1'b0; m_pend = 1'b0; m_prev = 1'b0; m_frame = 32'd0;
        end else begin
            m_err  = 1'b0;
            busy0  = m_busy;
            xfer_m = (q.size() != 0) && tx_ready;
            det    = frame_done && !m_prev;
            m_prev = frame_done;
            if (xfer_m) begin
                void'(q.pop_front());
                if (q.size() == 0) m_busy = 1'b0;
            end
            if (m_pend) begin
                m_pend = 1'b0;
                op = m_frame[31:24];
                a  = m_frame[23:0];
                ok = 1'b1;
                case (op)
                    8'h01: if (a == 24'd0) ok = 1'b0; else m_div = a;
                    8'h02: m_lvl = a[7:0];
                    8'h03: if (a[1:0] == 2'd3) ok = 1'b0; else begin m_mode = a[1:0]; m_edge = a[8]; end
                    8'h04: m_run = a[0];
                    8'h05: begin
                        case (a[1:0])
                            2'd0:    qv = m_div;
                            2'd1:    qv = 24'(m_lvl);
                            2'd2:    qv = 24'({m_edge, m_mode});
                            default: qv = 24'(m_run);
                        endcase
                        q.push_back(qv[23:16]);
                        q.push_back(qv[15:8]);
                        q.push_back(qv[7:0]);
                    end
                    default: ok = 1'b0;
                endcase
                if (ok) q.push_back(8'hA5);
                else begin q.push_back({4'hE, op[3:0]}); m_err = 1'b1; end
            end
            if (det) begin
                if (!busy0) begin m_pend = 1'b1; m_busy = 1'b1; m_frame = frame_data; end
                else m_err = 1'b1;
            end
            if (m_err && (m_cnt != 8'hFF)) m_cnt = m_cnt + 8'd1;
        end
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx_valid",   32'(tx_valid),   32'(q.size() != 0));
            if (q.size() != 0) chk("tx_data", 32'(tx_data), 32'(q[0]));
            chk("sample_div", 32'(sample_div), 32'(m_div));
            chk("trig_level", 32'(trig_level), 32'(m_lvl));
            chk("trig_mode",  32'(trig_mode),  32'(m_mode));
            chk("trig_edge",  32'(trig_edge),  32'(m_edge));
            chk("run",        32'(run),        32'(m_run));
            chk("cmd_err",    32'(cmd_err),    32'(m_err));
            chk("err_count",  32'(err_count),  32'(m_cnt));
        end
    end

    // Bytes actually handed to the transmitter
    logic [7:0] got[$];
    always @(negedge clk) begin
        if (!reset && tx_valid && tx_ready) got.push_back(tx_data);
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (toggle_rdy) tx_ready = !tx_ready;
    endtask

    task automatic send(input logic [31:0] f);
        frame_data = f;
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        step();
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 400; k++) begin
            if (!tx_valid && (q.size() == 0) && !m_busy) break;
            step();
        end
        checks++;
        if (k >= 400) begin
            errors++;
            $display("FAIL drain: response still pending after %0d cycles", k);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        got.delete();
    endtask

    task automatic expect_bytes(input string name, input int n, input logic [31:0] exp);
        chk({name, "_count"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got.size()) chk({name, "_byte"}, 32'(got[i]), 32'(8'(exp >> (8 * (n - 1 - i)))));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; frame_done = 1'b0; frame_data = 32'd0; tx_ready = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        chk("rst_div",   32'(sample_div), 32'd1000);
        chk("rst_level", 32'(trig_level), 32'h80);
        chk("rst_valid", 32'(tx_valid),   32'd0);
        chk("rst_errcnt", 32'(err_count), 32'd0);
        reset = 1'b0;
        got.delete();

        // Set divider, plain ACK
        send(32'h0100_0010);
        drain();
        chk("div_set", 32'(sample_div), 32'h10);
        expect_bytes("div_ack", 1, 32'hA5);
        chk("div_errcnt", 32'(err_count), 32'd0);

        // Illegal trigger mode rejected
        got.delete();
        send(32'h0300_0003);
        drain();
        chk("trig_mode_kept", 32'(trig_mode), 32'd0);
        chk("trig_edge_kept", 32'(trig_edge), 32'd0);
        expect_bytes("trig_rej", 1, 32'hE3);
        chk("trig_errcnt", 32'(err_count), 32'd1);

        // Divider query with back-pressure
        do_reset();
        toggle_rdy = 1'b1;
        send(32'h0500_0000);
        drain();
        toggle_rdy = 1'b0;
        tx_ready = 1'b1;
        expect_bytes("query_div", 4, 32'h0003_E8A5);

        // frame_done held high: one command only
        do_reset();
        frame_data = 32'h0400_0001;
        frame_done = 1'b1;
        repeat (20) step();
        frame_done = 1'b0;
        drain();
        chk("run_set", 32'(run), 32'd1);
        expect_bytes("held_done", 1, 32'hA5);

        // Overrun while stalled
        do_reset();
        tx_ready = 1'b0;
        send(32'h0200_0033);
        repeat (3) step();
        send(32'h0200_0044);
        step();
        chk("overrun_errcnt", 32'(err_count), 32'd1);
        tx_ready = 1'b1;
        drain();
        expect_bytes("overrun", 1, 32'hA5);
        chk("overrun_level", 32'(trig_level), 32'h33);

        // Reset in the middle of a query response
        do_reset();
        send(32'h0200_0011);
        drain();
        got.delete();
        send(32'h0500_0001);
        for (int k = 0; k < 20; k++) begin
            if (got.size() >= 1) break;
            step();
        end
        reset = 1'b1;
        step();
        chk("abort_valid", 32'(tx_valid),   32'd0);
        chk("abort_level", 32'(trig_level), 32'h80);
        chk("abort_div",   32'(sample_div), 32'd1000);
        reset = 1'b0;
        repeat (10) step();
        expect_bytes("abort", 1, 32'h00);

        // Error counter saturation via repeated overruns
        do_reset();
        tx_ready = 1'b0;
        send(32'h0400_0001);
        repeat (270) begin
            frame_done = 1'b1;
            step();
            frame_done = 1'b0;
            step();
        end
        chk("err_sat", 32'(err_count), 32'hFF);
        tx_ready = 1'b1;
        drain();

        // Random traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            reset    = ($urandom_range(0, 299) == 0);
            tx_ready = ($urandom_range(0, 3) != 0);
            if (frame_done) begin
                frame_done = ($urandom_range(0, 1) == 0);
            end else if ($urandom_range(0, 99) < 15) begin
                logic [7:0]  op;
                logic [23:0] a;
                op = 8'($urandom_range(0, 7));
                case ($urandom_range(0, 3))
                    0:       a = 24'd0;
                    1:       a = 24'd3;
                    2:       a = 24'($urandom_range(0, 3));
                    default: a = 24'($urandom);
                endcase
                frame_data = {op, a};
                frame_done = 1'b1;
            end
            step();
        end
        reset = 1'b0;
        frame_done = 1'b0;
        tx_ready = 1'b1;
        step();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
